state_dump: RTL and testbench

Debug readout engine that halts the CPU and streams out its architectural state: register bank contents, a RAM window, or both, as tagged words over a valid/ready stream. It sits beside `cpu`, drives the register-bank and RAM debug read ports, and gates the core through `cpu_halt`. It replaces fixed simulation-only dump loops with a synthesizable, parametrised unit usable on hardware.

---
 rtl/state_dump_if.sv | 24 ++
 rtl/state_dump.sv | 183 ++++++++++++++++++
 tb/tb_state_dump.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/state_dump_if.sv
// ---------------------------------------------------------------------------
// state_dump_if : output stream of the state_dump debug readout engine.
//
//   out_valid  master -> slave  word valid
//   out_ready  slave  -> master sink ready (transfer when valid & ready)
//   out_data   master -> slave  captured register or RAM word
//   out_tag    master -> slave  2'b00 register word, 2'b01 RAM word
//   out_index  master -> slave  register number (zero-extended) or RAM address
// ---------------------------------------------------------------------------
interface state_dump_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_tag;
    logic [IDX_WIDTH-1:0]  out_index;

    modport master (output out_valid, output out_data, output out_tag,
                    output out_index, input out_ready);
    modport slave  (input out_valid, input out_data, input out_tag,
                    input out_index, output out_ready);
endinterface

// File: rtl/state_dump.sv
// ---------------------------------------------------------------------------
// state_dump : halts the CPU and streams out the register bank, a RAM window,
// or both, as tagged words on a valid/ready stream.
//
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start, abort     begin a dump (sampled in IDLE) / terminate a running dump
//   mode             00 regs, 01 RAM, 1x regs then RAM (latched on start)
//   ram_base/count   RAM window start and length (latched on start)
//   cpu_halt, busy   high in every state except IDLE
//   done             one-cycle pulse after the dump or abort finishes
//   reg_addr/data    register-bank debug port (combinational read)
//   ram_addr/data    RAM debug port (synchronous read, 1-cycle latency)
//   out_s            output stream (state_dump_if master)
// ---------------------------------------------------------------------------
module state_dump #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_COUNT      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int SKIP_R0        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                mode,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_base,
    input  logic [RAM_ADDR_WIDTH:0]   ram_count,
    output logic                      cpu_halt,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]     ram_data,
    output logic                      busy,
    output logic                      done,
    state_dump_if.master              out_s
);

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_REG_RD, S_REG_OUT, S_RAM_RD, S_RAM_WAIT, S_RAM_OUT, S_DONE
    } state_e;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_FIRST =
        (SKIP_R0 != 0) ? REG_ADDR_WIDTH'(1) : '0;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_LAST = REG_ADDR_WIDTH'(REG_COUNT - 1);

    state_e                    state_q,     state_d;
    logic [1:0]                mode_q,      mode_d;
    logic [RAM_ADDR_WIDTH-1:0] base_q,      base_d;
    logic [RAM_ADDR_WIDTH:0]   count_q,     count_d;
    logic [REG_ADDR_WIDTH-1:0] reg_idx_q,   reg_idx_d;
    logic [RAM_ADDR_WIDTH:0]   ram_off_q,   ram_off_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_q,  out_data_d;
    logic [1:0]                out_tag_q,   out_tag_d;
    logic [RAM_ADDR_WIDTH-1:0] out_index_q, out_index_d;
    logic                      busy_q,      busy_d;
    logic                      done_q,      done_d;

    logic xfer;

    // Read addresses come straight from the counters; the RAM window wraps
    // naturally because the sum is truncated to RAM_ADDR_WIDTH bits.
    assign reg_addr = reg_idx_q;
    assign ram_addr = base_q + ram_off_q[RAM_ADDR_WIDTH-1:0];
    assign xfer     = out_valid_q && out_s.out_ready;

    always_comb begin
        // NOTE: every variable gets its default first so no path can infer a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        count_d     = count_q;
        reg_idx_d   = reg_idx_q;
        ram_off_d   = ram_off_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_index_d = out_index_q;
        // done trails the DONE state by one edge, so it fires as busy drops.
        done_d      = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    base_d    = ram_base;
                    count_d   = ram_count;
                    reg_idx_d = REG_FIRST;
                    ram_off_d = '0;
                    state_d   = S_HALT;
                end
            end
            S_HALT: begin
                if (mode_q == 2'b01) state_d = (count_q != '0) ? S_RAM_RD : S_DONE;
                else                 state_d = S_REG_RD;
            end
            S_REG_RD: begin
                out_data_d  = reg_data;
                out_tag_d   = 2'b00;
                out_index_d = RAM_ADDR_WIDTH'(reg_idx_q);
                state_d     = S_REG_OUT;
            end
            S_REG_OUT: begin
                if (xfer) begin
                    if (reg_idx_q == REG_LAST) begin
                        state_d = (mode_q[1] && count_q != '0) ? S_RAM_RD : S_DONE;
                    end else begin
                        reg_idx_d = reg_idx_q + 1'b1;
                        state_d   = S_REG_RD;
                    end
                end
            end
            S_RAM_RD:   state_d = S_RAM_WAIT;
            S_RAM_WAIT: begin
                // ram_data now reflects the address presented during RAM_RD.
                out_data_d  = ram_data;
                out_tag_d   = 2'b01;
                out_index_d = ram_addr;
                state_d     = S_RAM_OUT;
            end
            S_RAM_OUT: begin
                if (xfer) begin
                    if (ram_off_q + 1'b1 == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        ram_off_d = ram_off_q + 1'b1;
                        state_d   = S_RAM_RD;
                    end
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Abort overrides everything; a transfer on the same edge still
        // completes because the sink has already taken the word.
        if (abort && state_q != S_IDLE && state_q != S_DONE) state_d = S_DONE;

        out_valid_d = (state_d == S_REG_OUT) || (state_d == S_RAM_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            count_q     <= '0;
            reg_idx_q   <= '0;
            ram_off_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            count_q     <= count_d;
            reg_idx_q   <= reg_idx_d;
            ram_off_q   <= ram_off_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cpu_halt        = busy_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign out_s.out_valid = out_valid_q;
    assign out_s.out_data  = out_data_q;
    assign out_s.out_tag   = out_tag_q;
    assign out_s.out_index = out_index_q;

endmodule

// File: tb/tb_state_dump.sv
// ---------------------------------------------------------------------------
// tb_state_dump : directed self-checking bench for state_dump.
// Register bank model returns r_i = i*0x11; RAM model holds 0xC0DE0000 + 3*a
// with a one-cycle registered read. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_state_dump;

    localparam int DW  = 32;
    localparam int RGW = 5;
    localparam int RAW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [RAW-1:0] ram_base = '0;
    logic [RAW:0]   ram_count = '0;
    logic           cpu_halt;
    logic [RGW-1:0] reg_addr;
    logic [DW-1:0]  reg_data;
    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_data;
    logic           busy;
    logic           done;

    logic [DW-1:0]  ram_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]     exp_tag  [400];
    logic [RAW-1:0] exp_idx  [400];
    logic [DW-1:0]  exp_data [400];
    int             n_exp;

    state_dump_if #(.DATA_WIDTH(DW), .IDX_WIDTH(RAW)) sif ();

    state_dump #(
        .DATA_WIDTH(DW), .REG_COUNT(32), .REG_ADDR_WIDTH(RGW),
        .RAM_ADDR_WIDTH(RAW), .SKIP_R0(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .ram_base(ram_base), .ram_count(ram_count), .cpu_halt(cpu_halt),
        .reg_addr(reg_addr), .reg_data(reg_data), .ram_addr(ram_addr),
        .ram_data(ram_data), .busy(busy), .done(done), .out_s(sif)
    );

    always #5 clk = ~clk;

    assign reg_data = {27'b0, reg_addr} * 32'h11;
    always @(posedge clk) ram_data <= ram_mem[ram_addr];

    function automatic logic [DW-1:0] ram_word(input logic [RAW-1:0] a);
        return 32'hC0DE_0000 + 32'(a) * 32'd3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_regs();
        for (int i = 1; i < 32; i++) begin
            exp_tag[n_exp]  = 2'b00;
            exp_idx[n_exp]  = 8'(i);
            exp_data[n_exp] = 32'(i * 17);
            n_exp++;
        end
    endtask

    task automatic add_ram(input logic [RAW-1:0] base, input int cnt);
        logic [RAW-1:0] a;
        for (int k = 0; k < cnt; k++) begin
            a = base + 8'(k);
            exp_tag[n_exp]  = 2'b01;
            exp_idx[n_exp]  = a;
            exp_data[n_exp] = ram_word(a);
            n_exp++;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_cpu_halt"},  64'(cpu_halt), 64'd0);
        check({pfx, "_busy"},      64'(busy), 64'd0);
        check({pfx, "_done"},      64'(done), 64'd0);
        check({pfx, "_out_valid"}, 64'(sif.out_valid), 64'd0);
        check({pfx, "_out_data"},  64'(sif.out_data), 64'd0);
        check({pfx, "_out_tag"},   64'(sif.out_tag), 64'd0);
        check({pfx, "_out_index"}, 64'(sif.out_index), 64'd0);
        check({pfx, "_reg_addr"},  64'(reg_addr), 64'd0);
        check({pfx, "_ram_addr"},  64'(ram_addr), 64'd0);
    endtask

    // Pulses start across one rising edge (edge N), then scrambles the
    // configuration inputs so only the latched copy can produce the right dump.
    task automatic start_dump(input logic [1:0] m, input logic [RAW-1:0] b, input logic [RAW:0] c);
        @(negedge clk);
        mode = m; ram_base = b; ram_count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = m ^ 2'b11; ram_base = 8'h33; ram_count = '0;
    endtask

    // Called at the falling edge after edge N; cycle 0 is that point.
    task automatic run_stream(input string name, input int first_cyc, input int spacing,
                              input bit rand_ready, input int budget);
        int got = 0, cyc = 0, last = -1, first = -1, done_cyc = -1, want_done;
        bit stall = 1'b0;
        logic [DW-1:0] pd; logic [1:0] pt; logic [RAW-1:0] pi;
        check({name, "_halt_c0"}, 64'(cpu_halt), 64'd1);
        check({name, "_busy_c0"}, 64'(busy), 64'd1);
        while (cyc < budget) begin
            sif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                check({name, "_stall_valid"}, 64'(sif.out_valid), 64'd1);
                check({name, "_stall_data"},  64'(sif.out_data), 64'(pd));
                check({name, "_stall_tag"},   64'(sif.out_tag), 64'(pt));
                check({name, "_stall_index"}, 64'(sif.out_index), 64'(pi));
            end
            if (sif.out_valid && first < 0) first = cyc;
            if (sif.out_valid && sif.out_ready) begin
                if (got < n_exp) begin
                    check({name, "_tag"},   64'(sif.out_tag), 64'(exp_tag[got]));
                    check({name, "_index"}, 64'(sif.out_index), 64'(exp_idx[got]));
                    check({name, "_data"},  64'(sif.out_data), 64'(exp_data[got]));
                    if (spacing > 0 && got > 0)
                        check({name, "_spacing"}, 64'(cyc - last), 64'(spacing));
                end else begin
                    check({name, "_extra_word"}, 64'd1, 64'd0);
                end
                last = cyc;
                got++;
            end
            stall = sif.out_valid && !sif.out_ready;
            pd = sif.out_data; pt = sif.out_tag; pi = sif.out_index;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        sif.out_ready = 1'b1;
        check({name, "_word_count"}, 64'(got), 64'(n_exp));
        check({name, "_first_valid"}, 64'(first), 64'(first_cyc));
        want_done = (n_exp == 0) ? 2 : last + 2;
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(want_done));
        if (done_cyc >= 0) begin
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            check({name, "_halt_at_done"}, 64'(cpu_halt), 64'd0);
            check({name, "_valid_at_done"}, 64'(sif.out_valid), 64'd0);
            @(negedge clk);
            check({name, "_done_one_cycle"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int k;
        sif.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) ram_mem[i] = ram_word(8'(i));

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Registers only, ready held high: 31 words, 2-cycle spacing
        n_exp = 0; add_regs();
        start_dump(2'b00, 8'h00, 9'd0);
        run_stream("regs", 2, 2, 1'b0, 200);

        // RAM only across the top of the address space
        n_exp = 0; add_ram(8'hFE, 4);
        start_dump(2'b01, 8'hFE, 9'd4);
        run_stream("ram_wrap", 3, 3, 1'b0, 100);

        // Registers then RAM with a randomly stalling sink
        n_exp = 0; add_regs(); add_ram(8'h40, 6);
        start_dump(2'b10, 8'h40, 9'd6);
        run_stream("both_rand", 2, 0, 1'b1, 2000);

        // Empty RAM window: HALT then DONE, no words
        n_exp = 0;
        start_dump(2'b01, 8'h20, 9'd0);
        run_stream("ram_empty", -1, 0, 1'b0, 20);

        // Abort while the 5th register word is stalled
        start_dump(2'b00, 8'h00, 9'd0);
        k = 0;
        while (k < 100 && !(sif.out_valid && sif.out_index == 8'd5)) begin
            sif.out_ready = 1'b1;
            @(negedge clk);
            k++;
        end
        sif.out_ready = 1'b0;
        check("abort_w5_seen", 64'(k < 100), 64'd1);
        check("abort_w5_data", 64'(sif.out_data), 64'h55);
        @(negedge clk);
        check("abort_w5_held", 64'(sif.out_index), 64'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid_dropped", 64'(sif.out_valid), 64'd0);
        check("abort_busy_in_done", 64'(busy), 64'd1);
        check("abort_no_early_done", 64'(done), 64'd0);
        @(negedge clk);
        check("abort_done", 64'(done), 64'd1);
        check("abort_halt_low", 64'(cpu_halt), 64'd0);
        @(negedge clk);
        check("abort_done_once", 64'(done), 64'd0);
        check("abort_still_idle", 64'(sif.out_valid), 64'd0);
        sif.out_ready = 1'b1;

        // Reset during RAM_OUT
        start_dump(2'b01, 8'h10, 9'd5);
        sif.out_ready = 1'b0;
        k = 0;
        while (k < 20 && !sif.out_valid) begin
            @(negedge clk);
            k++;
        end
        check("rst_word_seen", 64'(sif.out_valid), 64'd1);
        check("rst_word_index", 64'(sif.out_index), 64'h10);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        repeat (2) begin
            @(negedge clk);
            check("reset_hold_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        sif.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_done", 64'(done), 64'd0);
            check("post_reset_busy", 64'(busy), 64'd0);
        end

        // Normal dump after reset
        n_exp = 0; add_ram(8'h80, 2);
        start_dump(2'b01, 8'h80, 9'd2);
        run_stream("after_reset", 3, 3, 1'b0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
